amo_sequencer: RTL and testbench
================================

# amo_sequencer

Multi-cycle controller for RV32A atomic instructions (LR.W, SC.W, AMO*.W). Sits beside the execute stage: once the decoder has classified an instruction as atomic, this block takes over the data-memory port and runs the load / modify / store sequence. It also keeps the single LR/SC reservation and returns the value to be written to rd. The pipeline stalls on `busy` and retires the instruction on `done`.

## Interface
Parameters:
- `ADDR_W`, 32: data-memory address width.
- `XLEN`, 32: data width.

Ports:
- `CLK`, in, 1: clock, rising-edge.
- `nRST`, in, 1: asynchronous active-low reset.
- `start`, in, 1: atomic instruction valid. Sampled only in IDLE.
- `funct5`, in, 5: atomic opcode, inst[31:27].
- `addr`, in, ADDR_W: rs1 value, the effective address. Captured on start.
- `rs2_data`, in, XLEN: rs2 value. Captured on start.
- `clear_resv`, in, 1: invalidate the reservation (trap, context switch, or a regular store hitting the reserved word).
- `busy`, out, 1: sequence in progress. Pipeline holds.
- `done`, out, 1: one-cycle pulse. `rd_data` and the error flags are valid in this cycle.
- `rd_data`, out, XLEN: write-back value.
- `misaligned`, out, 1: addr[1:0] != 0. Valid with `done`.
- `illegal`, out, 1: unsupported funct5. Valid with `done`.
- `dmem_ren`, out, 1: memory read request.
- `dmem_wen`, out, 1: memory write request.
- `dmem_addr`, out, ADDR_W: word address, equal to the captured addr.
- `dmem_wdata`, out, XLEN: store data.
- `dmem_rdata`, in, XLEN: load data. Valid when `dmem_ready` is high during a read.
- `dmem_ready`, in, 1: completes the current request in this cycle.

## Operation
- funct5 encodings:
  - LR=00010, SC=00011
  - SWAP=00001, ADD=00000, XOR=00100, OR=01000, AND=01100
  - MIN=10000, MAX=10100, MINU=11000, MAXU=11100
  - Any other value is illegal.
- FSM states: IDLE, READ, WRITE, DONE.
- From IDLE, when `start` is high, register funct5, addr and rs2_data, then:
  - addr[1:0] != 0: go to DONE with misaligned=1 and rd_data=0. No memory access.
  - Illegal funct5: go to DONE with illegal=1 and rd_data=0. No memory access. Misaligned has priority over illegal.
  - LR or AMO: go to READ.
  - SC with reservation valid and resv_addr == addr: go to WRITE.
  - SC otherwise: go to DONE with rd_data=1. No write. Reservation cleared.
- READ: `dmem_ren`=1. Hold the request until `dmem_ready`. On ready, capture old=`dmem_rdata`, then:
  - LR: set resv_valid=1, resv_addr=addr, rd_data=old, go to DONE.
  - AMO: go to WRITE.
- WRITE: `dmem_wen`=1 and `dmem_wdata`=new. Hold until `dmem_ready`, then go to DONE.
  - SC: rd_data=0, reservation cleared.
  - AMO: rd_data=old.
- new value (AMO), computed combinationally from old and rs2:
  - SWAP: rs2. ADD: old+rs2, modulo 2^32, no overflow flag.
  - XOR / OR / AND: bitwise.
  - MIN / MAX: signed compare. MINU / MAXU: unsigned compare.
- SC write data is rs2.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. Error flags clear on leaving DONE.
- `busy`=1 in READ and WRITE. `busy`=1 also in the IDLE cycle where `start` is accepted, so the pipeline stalls immediately.
- `dmem_ren` and `dmem_wen` are never high together. `dmem_addr`=0 when neither is high.
- `start` while not IDLE is ignored.
- Reservation rules:
  - `clear_resv` clears it in any state, with priority over an LR set in the same cycle.
  - An LR to a new address replaces the existing reservation.
  - An SC, successful or failed, always clears it.
  - The reservation is kept across misaligned or illegal ops.

## Timing
- Reset values: all outputs 0, state=IDLE, resv_valid=0, captured registers 0. Reset is asynchronous and takes effect mid-sequence: a pending dmem request drops immediately and no `done` is produced.
- Latency from the start cycle to the done cycle, with zero-wait memory (ready in the same cycle as the request):
  - LR: 2 cycles.
  - SC success: 2 cycles.
  - AMO: 3 cycles.
  - SC fail, misaligned, illegal: 1 cycle.
- Each wait cycle (ready low) adds one cycle. Request signals stay stable while waiting.
- Back-to-back: a new `start` is accepted in the cycle after `done`, not in the `done` cycle.

## Test plan
- AMOADD: mem[0x100]=5, rs2=7, ready tied high → ren in cycle 1, wen with wdata=12 in cycle 2, done in cycle 3 with rd_data=5.
- LR then SC:
  - LR 0x200 with mem=0xAA → rd_data=0xAA, reservation set.
  - SC 0x200 with rs2=0x55 → write 0x55, rd_data=0.
  - A second SC 0x200 → no write, rd_data=1.
- Reservation loss:
  - LR 0x200, then clear_resv pulse, then SC 0x200 → fails with rd_data=1 and no dmem_wen.
  - LR 0x200, then SC 0x204 → fails with rd_data=1 and no dmem_wen.
- Signed vs unsigned: old=0xFFFFFFFF, rs2=1 → AMOMIN stores 0xFFFFFFFF, AMOMINU stores 1. Both return rd_data=0xFFFFFFFF.
- Errors:
  - addr=0x102 with AMOSWAP → done after 1 cycle with misaligned=1, no dmem access.
  - funct5=11111 → illegal=1, no dmem access.
- Stalls and reset:
  - ready held low for 3 cycles in READ → ren and addr stay stable, done is 3 cycles late.
  - nRST asserted while in WRITE → wen drops asynchronously, resv_valid=0, no done.

Source files
------------

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: owns the data-memory port for LR.W / SC.W / AMO*.W,
// runs the read-modify-write sequence and keeps the single LR/SC reservation.
module amo_sequencer #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [4:0]        funct5,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              clear_resv,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   rd_data,
    output logic              misaligned,
    output logic              illegal,
    output logic              dmem_ren,
    output logic              dmem_wen,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ready
);

    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [4:0]        op;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   rs2_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   new_val;
    logic              resv_valid;
    logic [ADDR_W-1:0] resv_addr;

    function automatic logic is_legal(input logic [4:0] f);
        case (f)
            F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_OR, F_AND,
            F_MIN, F_MAX, F_MINU, F_MAXU: is_legal = 1'b1;
            default:                      is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] amo_result(input logic [4:0] f,
                                                   input logic [XLEN-1:0] old,
                                                   input logic [XLEN-1:0] rs2);
        logic signed [XLEN-1:0] s_old;
        logic signed [XLEN-1:0] s_rs2;
        s_old = old;
        s_rs2 = rs2;
        case (f)
            F_ADD:   amo_result = old + rs2;
            F_XOR:   amo_result = old ^ rs2;
            F_OR:    amo_result = old | rs2;
            F_AND:   amo_result = old & rs2;
            F_MIN:   amo_result = (s_old < s_rs2) ? old : rs2;
            F_MAX:   amo_result = (s_old > s_rs2) ? old : rs2;
            F_MINU:  amo_result = (old < rs2) ? old : rs2;
            F_MAXU:  amo_result = (old > rs2) ? old : rs2;
            default: amo_result = rs2;
        endcase
    endfunction

    // Decode of the incoming instruction, used only in the accepting IDLE cycle.
    logic in_misaligned;
    logic in_illegal;
    logic in_sc;
    logic sc_hit;
    logic op_lr;
    logic op_sc;

    assign in_misaligned = (addr[1:0] != 2'b00);
    assign in_illegal    = !is_legal(funct5);
    assign in_sc         = (funct5 == F_SC);
    assign sc_hit        = resv_valid && (resv_addr == addr);
    assign op_lr         = (op == F_LR);
    assign op_sc         = (op == F_SC);
    assign new_val       = amo_result(op, old_q, rs2_q);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (in_misaligned || in_illegal) state_next = DONE;
                    else if (in_sc)                  state_next = sc_hit ? WRITE : DONE;
                    else                             state_next = READ;
                end
            end
            READ:  if (dmem_ready) state_next = op_lr ? DONE : WRITE;
            WRITE: if (dmem_ready) state_next = DONE;
            DONE:  state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        case (state)
            IDLE: busy = start;
            READ: begin
                busy      = 1'b1;
                dmem_ren  = 1'b1;
                dmem_addr = addr_q;
            end
            WRITE: begin
                busy       = 1'b1;
                dmem_wen   = 1'b1;
                dmem_addr  = addr_q;
                dmem_wdata = op_sc ? rs2_q : new_val;
            end
            DONE: done = 1'b1;
        endcase
    end

    // Captured operands and the registered results presented with done.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op         <= '0;
            addr_q     <= '0;
            rs2_q      <= '0;
            old_q      <= '0;
            rd_data    <= '0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op         <= funct5;
                        addr_q     <= addr;
                        rs2_q      <= rs2_data;
                        misaligned <= in_misaligned;
                        illegal    <= !in_misaligned && in_illegal;
                        if (in_misaligned || in_illegal) rd_data <= '0;
                        else if (in_sc && !sc_hit)       rd_data <= XLEN'(1);
                    end
                end
                READ: begin
                    if (dmem_ready) begin
                        old_q <= dmem_rdata;
                        if (op_lr) rd_data <= dmem_rdata;
                    end
                end
                WRITE: if (dmem_ready) rd_data <= op_sc ? '0 : old_q;
                DONE: begin
                    misaligned <= 1'b0;
                    illegal    <= 1'b0;
                end
            endcase
        end
    end

    // clear_resv wins over an LR completing in the same cycle; any aligned SC drops it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else if (clear_resv) begin
            resv_valid <= 1'b0;
        end else if (state == IDLE && start && in_sc && !in_misaligned) begin
            resv_valid <= 1'b0;
        end else if (state == READ && dmem_ready && op_lr) begin
            resv_valid <= 1'b1;
            resv_addr  <= addr_q;
        end
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// Bench for amo_sequencer: memory responder with wait states, a table of directed
// vectors, hand sequences for reset corners, and random ops against a reference model.
module tb_amo_sequencer;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic [4:0]  funct5;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic        clear_resv;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic        misaligned;
    logic        illegal;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    amo_sequencer #(.ADDR_W(32), .XLEN(32)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .funct5(funct5), .addr(addr),
        .rs2_data(rs2_data), .clear_resv(clear_resv), .busy(busy), .done(done),
        .rd_data(rd_data), .misaligned(misaligned), .illegal(illegal),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [4:0] LR = 5'b00010, SC = 5'b00011, SWAP = 5'b00001, ADD = 5'b00000;
    localparam logic [4:0] XOR = 5'b00100, OR = 5'b01000, AND = 5'b01100;
    localparam logic [4:0] MIN = 5'b10000, MAX = 5'b10100, MINU = 5'b11000, MAXU = 5'b11100;
    localparam logic [4:0] BAD = 5'b11111;

    typedef struct {
        logic [31:0] rd;
        bit          mis;
        bit          ill;
        bit          rdx;
        bit          wen;
        logic [31:0] wd;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] rd;
        bit          mis;
        bit          ill;
        bit          rdx;
        bit          wen;
        logic [31:0] wd;
        int          lat;
        bit          ok;
    } obs_t;

    typedef struct {
        logic [4:0]  f5;
        logic [31:0] a;
        logic [31:0] r2;
        int          rw;
        int          ww;
        int          clr;
        bit          pre;
        logic [31:0] pv;
        exp_t        e;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [logic [31:0]];
    bit          m_resv_v;
    logic [31:0] m_resv_a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hDEAD0000 ^ a);
    endfunction

    // Reference: what the instruction must do, judged from architectural rules.
    task automatic model_step(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] r2,
                              input int rw, input int ww, input int clr, output exp_t e);
        logic [31:0] old;
        bit legal;
        e = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1};
        if (clr == 1) m_resv_v = 1'b0;
        legal = f5 inside {LR, SC, SWAP, ADD, XOR, OR, AND, MIN, MAX, MINU, MAXU};
        old = mem_rd(a);
        if (a[1:0] != 2'b00) begin
            e.mis = 1'b1;
        end else if (!legal) begin
            e.ill = 1'b1;
        end else if (f5 == LR) begin
            e.rdx = 1'b1; e.rd = old; e.lat = 2 + rw;
            m_resv_v = 1'b1; m_resv_a = a;
        end else if (f5 == SC) begin
            if (m_resv_v && m_resv_a == a) begin
                e.wen = 1'b1; e.wd = r2; e.rd = 32'h0; e.lat = 2 + ww;
            end else begin
                e.rd = 32'h1;
            end
            m_resv_v = 1'b0;
        end else begin
            e.rdx = 1'b1; e.wen = 1'b1; e.rd = old; e.lat = 3 + rw + ww;
            case (f5)
                SWAP: e.wd = r2;
                ADD:  e.wd = old + r2;
                XOR:  e.wd = old ^ r2;
                OR:   e.wd = old | r2;
                AND:  e.wd = old & r2;
                MIN:  e.wd = ($signed(old) < $signed(r2)) ? old : r2;
                MAX:  e.wd = ($signed(old) > $signed(r2)) ? old : r2;
                MINU: e.wd = (old < r2) ? old : r2;
                default: e.wd = (old > r2) ? old : r2;
            endcase
        end
        if (clr == 2) m_resv_v = 1'b0;
    endtask

    // Issue one op (called just after a falling edge) and act as the memory.
    task automatic run_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] r2,
                          input int rw, input int ww, input int clr, input bit poke,
                          output obs_t o);
        int  rc = 0;
        int  wc = 0;
        bit  got = 0;
        bit  wfirst = 1;
        logic [31:0] w0 = 32'h0;
        o = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b1};
        if (clr == 1) begin
            clear_resv = 1'b1;
            @(negedge CLK);
            clear_resv = 1'b0;
        end
        if (clr == 2) clear_resv = 1'b1;
        start = 1'b1; funct5 = f5; addr = a; rs2_data = r2; dmem_ready = 1'b0;
        #1 chk("busy_on_start", {31'h0, busy}, 32'h1);
        for (int c = 1; c <= 20 + rw + ww; c++) begin
            @(negedge CLK);
            start = 1'b0; funct5 = 5'($urandom); addr = $urandom; rs2_data = $urandom;
            if (dmem_ren && dmem_wen) o.ok = 1'b0;
            if ((dmem_ren || dmem_wen) && !busy) o.ok = 1'b0;
            if (dmem_ren) begin
                o.rdx = 1'b1;
                if (dmem_addr != a) o.ok = 1'b0;
                if (rc < rw) begin
                    dmem_ready = 1'b0; dmem_rdata = $urandom; rc++;
                end else begin
                    dmem_ready = 1'b1; dmem_rdata = mem_rd(a);
                end
            end else if (dmem_wen) begin
                o.wen = 1'b1;
                if (dmem_addr != a) o.ok = 1'b0;
                if (wfirst) begin w0 = dmem_wdata; wfirst = 0; end
                else if (dmem_wdata != w0) o.ok = 1'b0;
                if (wc < ww) begin
                    dmem_ready = 1'b0; wc++;
                end else begin
                    dmem_ready = 1'b1; o.wd = dmem_wdata; mem[a] = dmem_wdata;
                end
            end else begin
                dmem_ready = 1'b0;
                if (dmem_addr != 32'h0) o.ok = 1'b0;
                if (done) begin
                    if (busy) o.ok = 1'b0;
                    o.rd = rd_data; o.mis = misaligned; o.ill = illegal; o.lat = c;
                    got = 1;
                    break;
                end
            end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL timeout: no done within budget for funct5=%b addr=%h", f5, a);
        end
        if (poke) begin
            start = 1'b1; funct5 = SWAP; addr = 32'h100;
        end
        @(negedge CLK);
        start = 1'b0;
        clear_resv = 1'b0;
        #1;
        chk("after_done.done", {31'h0, done}, 32'h0);
        chk("after_done.busy", {31'h0, busy}, 32'h0);
        chk("after_done.flags", {30'h0, misaligned, illegal}, 32'h0);
    endtask

    task automatic compare(input string tag, input obs_t o, input exp_t e);
        chk({tag, ".rd_data"}, o.rd, e.rd);
        chk({tag, ".misaligned"}, {31'h0, o.mis}, {31'h0, e.mis});
        chk({tag, ".illegal"}, {31'h0, o.ill}, {31'h0, e.ill});
        chk({tag, ".read_seen"}, {31'h0, o.rdx}, {31'h0, e.rdx});
        chk({tag, ".write_seen"}, {31'h0, o.wen}, {31'h0, e.wen});
        if (e.wen) chk({tag, ".wdata"}, o.wd, e.wd);
        chk({tag, ".latency"}, o.lat, e.lat);
        chk({tag, ".port_rules"}, {31'h0, o.ok}, 32'h1);
    endtask

    vec_t tbl[$];

    initial begin
        obs_t o;
        exp_t e;
        exp_t m;
        logic [4:0] amos [9] = '{SWAP, ADD, XOR, OR, AND, MIN, MAX, MINU, MAXU};
        logic [31:0] pool [5] = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'h801};
        bit seen;

        //            f5    addr        rs2          rw ww clr pre pv             rd           mis ill rdx wen wd           lat
        tbl.push_back('{ADD,  32'h100, 32'h7,        0, 0, 0, 1, 32'h5,        '{32'h5,        0, 0, 1, 1, 32'hC,        3}});
        tbl.push_back('{LR,   32'h200, 32'h0,        0, 0, 0, 1, 32'hAA,       '{32'hAA,       0, 0, 1, 0, 32'h0,        2}});
        tbl.push_back('{SC,   32'h200, 32'h55,       0, 0, 0, 0, 32'h0,        '{32'h0,        0, 0, 0, 1, 32'h55,       2}});
        tbl.push_back('{SC,   32'h200, 32'h66,       0, 0, 0, 0, 32'h0,        '{32'h1,        0, 0, 0, 0, 32'h0,        1}});
        tbl.push_back('{LR,   32'h200, 32'h0,        0, 0, 0, 0, 32'h0,        '{32'h55,       0, 0, 1, 0, 32'h0,        2}});
        tbl.push_back('{SC,   32'h200, 32'h77,       0, 0, 1, 0, 32'h0,        '{32'h1,        0, 0, 0, 0, 32'h0,        1}});
        tbl.push_back('{LR,   32'h200, 32'h0,        0, 0, 0, 0, 32'h0,        '{32'h55,       0, 0, 1, 0, 32'h0,        2}});
        tbl.push_back('{SC,   32'h204, 32'h77,       0, 0, 0, 0, 32'h0,        '{32'h1,        0, 0, 0, 0, 32'h0,        1}});
        tbl.push_back('{LR,   32'h200, 32'h0,        0, 0, 2, 0, 32'h0,        '{32'h55,       0, 0, 1, 0, 32'h0,        2}});
        tbl.push_back('{SC,   32'h200, 32'h77,       0, 0, 0, 0, 32'h0,        '{32'h1,        0, 0, 0, 0, 32'h0,        1}});
        tbl.push_back('{MIN,  32'h300, 32'h1,        0, 0, 0, 1, 32'hFFFFFFFF, '{32'hFFFFFFFF, 0, 0, 1, 1, 32'hFFFFFFFF, 3}});
        tbl.push_back('{MINU, 32'h300, 32'h1,        0, 0, 0, 1, 32'hFFFFFFFF, '{32'hFFFFFFFF, 0, 0, 1, 1, 32'h1,        3}});
        tbl.push_back('{SWAP, 32'h102, 32'h0,        0, 0, 0, 0, 32'h0,        '{32'h0,        1, 0, 0, 0, 32'h0,        1}});
        tbl.push_back('{BAD,  32'h100, 32'h0,        0, 0, 0, 0, 32'h0,        '{32'h0,        0, 1, 0, 0, 32'h0,        1}});
        tbl.push_back('{BAD,  32'h103, 32'h0,        0, 0, 0, 0, 32'h0,        '{32'h0,        1, 0, 0, 0, 32'h0,        1}});
        tbl.push_back('{ADD,  32'h100, 32'h3,        3, 0, 0, 1, 32'hA,        '{32'hA,        0, 0, 1, 1, 32'hD,        6}});
        tbl.push_back('{MAX,  32'h400, 32'h5,        0, 0, 0, 1, 32'h80000000, '{32'h80000000, 0, 0, 1, 1, 32'h5,        3}});
        tbl.push_back('{MAXU, 32'h400, 32'h5,        0, 0, 0, 1, 32'h80000000, '{32'h80000000, 0, 0, 1, 1, 32'h80000000, 3}});
        tbl.push_back('{XOR,  32'h404, 32'h0FF0,     0, 0, 0, 1, 32'hF0F0,     '{32'hF0F0,     0, 0, 1, 1, 32'hFF00,     3}});
        tbl.push_back('{OR,   32'h404, 32'h0FF0,     0, 0, 0, 1, 32'hF0F0,     '{32'hF0F0,     0, 0, 1, 1, 32'hFFF0,     3}});
        tbl.push_back('{AND,  32'h404, 32'h0FF0,     0, 0, 0, 1, 32'hF0F0,     '{32'hF0F0,     0, 0, 1, 1, 32'h00F0,     3}});
        tbl.push_back('{SWAP, 32'h408, 32'hABCD,     0, 2, 0, 1, 32'h1234,     '{32'h1234,     0, 0, 1, 1, 32'hABCD,     5}});
        tbl.push_back('{LR,   32'h500, 32'h0,        0, 0, 0, 1, 32'h7,        '{32'h7,        0, 0, 1, 0, 32'h0,        2}});
        tbl.push_back('{SC,   32'h502, 32'h9,        0, 0, 0, 0, 32'h0,        '{32'h0,        1, 0, 0, 0, 32'h0,        1}});
        tbl.push_back('{SC,   32'h500, 32'h9,        0, 1, 0, 0, 32'h0,        '{32'h0,        0, 0, 0, 1, 32'h9,        3}});
        tbl.push_back('{LR,   32'h600, 32'h0,        1, 0, 0, 1, 32'h3,        '{32'h3,        0, 0, 1, 0, 32'h0,        3}});
        tbl.push_back('{LR,   32'h604, 32'h0,        0, 0, 0, 1, 32'h4,        '{32'h4,        0, 0, 1, 0, 32'h0,        2}});
        tbl.push_back('{SC,   32'h600, 32'h2,        0, 0, 0, 0, 32'h0,        '{32'h1,        0, 0, 0, 0, 32'h0,        1}});
        tbl.push_back('{LR,   32'h700, 32'h0,        0, 0, 0, 1, 32'h8,        '{32'h8,        0, 0, 1, 0, 32'h0,        2}});
        tbl.push_back('{BAD,  32'h700, 32'h0,        0, 0, 0, 0, 32'h0,        '{32'h0,        0, 1, 0, 0, 32'h0,        1}});
        tbl.push_back('{SC,   32'h700, 32'h1,        0, 0, 0, 0, 32'h0,        '{32'h0,        0, 0, 0, 1, 32'h1,        2}});

        nRST = 1'b0; start = 1'b0; funct5 = 5'h0; addr = 32'h0; rs2_data = 32'h0;
        clear_resv = 1'b0; dmem_rdata = 32'h0; dmem_ready = 1'b0;
        m_resv_v = 1'b0; m_resv_a = 32'h0;
        repeat (2) @(negedge CLK);
        chk("reset.busy", {31'h0, busy}, 32'h0);
        chk("reset.done", {31'h0, done}, 32'h0);
        chk("reset.rd_data", rd_data, 32'h0);
        chk("reset.flags", {30'h0, misaligned, illegal}, 32'h0);
        chk("reset.req", {30'h0, dmem_ren, dmem_wen}, 32'h0);
        chk("reset.dmem_addr", dmem_addr, 32'h0);
        chk("reset.dmem_wdata", dmem_wdata, 32'h0);
        nRST = 1'b1;
        @(negedge CLK);

        foreach (tbl[i]) begin
            if (tbl[i].pre) mem[tbl[i].a] = tbl[i].pv;
            model_step(tbl[i].f5, tbl[i].a, tbl[i].r2, tbl[i].rw, tbl[i].ww, tbl[i].clr, m);
            run_op(tbl[i].f5, tbl[i].a, tbl[i].r2, tbl[i].rw, tbl[i].ww, tbl[i].clr, 1'b0, o);
            compare($sformatf("vec%0d", i), o, tbl[i].e);
        end

        // Reset in the middle of a stalled write: request drops at once, no done,
        // reservation gone.
        model_step(LR, 32'h600, 32'h0, 0, 0, 0, e);
        run_op(LR, 32'h600, 32'h0, 0, 0, 0, 1'b0, o);
        compare("rst_lr", o, e);
        start = 1'b1; funct5 = ADD; addr = 32'h600; rs2_data = 32'h1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLK);
            start = 1'b0;
            if (dmem_ren) begin dmem_ready = 1'b1; dmem_rdata = mem_rd(32'h600); end
            else if (dmem_wen) begin dmem_ready = 1'b0; seen = 1; end
        end
        chk("rst.reached_write", {31'h0, seen}, 32'h1);
        #2 nRST = 1'b0;
        #1;
        chk("rst.wen_drop", {31'h0, dmem_wen}, 32'h0);
        chk("rst.busy_drop", {31'h0, busy}, 32'h0);
        chk("rst.addr_drop", dmem_addr, 32'h0);
        @(negedge CLK);
        chk("rst.no_done", {31'h0, done}, 32'h0);
        nRST = 1'b1;
        m_resv_v = 1'b0;
        @(negedge CLK);
        chk("rst.idle_done", {31'h0, done}, 32'h0);
        model_step(SC, 32'h600, 32'h5, 0, 0, 0, e);
        run_op(SC, 32'h600, 32'h5, 0, 0, 0, 1'b0, o);
        compare("rst_sc", o, e);
        chk("rst.sc_failed", o.rd, 32'h1);

        // Random ops against the reference model.
        foreach (pool[i]) mem[pool[i]] = $urandom;
        for (int n = 0; n < 250; n++) begin
            logic [4:0]  f5;
            logic [31:0] a;
            logic [31:0] r2;
            int rw;
            int ww;
            int clr;
            int k;
            k  = $urandom_range(0, 15);
            if (k < 3)       f5 = LR;
            else if (k < 6)  f5 = SC;
            else if (k == 6) f5 = ($urandom_range(0, 1) == 1) ? BAD : 5'b00101;
            else             f5 = amos[$urandom_range(0, 8)];
            a  = ($urandom_range(0, 15) == 0) ? pool[4] : pool[$urandom_range(0, 3)];
            r2 = ($urandom_range(0, 3) == 0) ? 32'h80000000 ^ 32'($urandom_range(0, 3)) : $urandom;
            rw = $urandom_range(0, 2);
            ww = $urandom_range(0, 2);
            k  = $urandom_range(0, 15);
            clr = (k == 0) ? 1 : (k == 1) ? 2 : 0;
            model_step(f5, a, r2, rw, ww, clr, e);
            run_op(f5, a, r2, rw, ww, clr, ($urandom_range(0, 7) == 0), o);
            compare($sformatf("rnd%0d", n), o, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
